id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register for a five-stage LEGv8-style pipeline. It picks the
// Rn/Rm operands (forwarding from the EX/MEM and MEM/WB writers, with X31
// hard-wired to zero) and registers them with the immediate, destination
// register and control word for the EX stage. It also detects load-use
// hazards and inserts a one-cycle bubble for stalls, flushes and empty slots.
//
// Ports
//   clk                       rising-edge clock
//   reset                     asynchronous, active-low; clears all state
//   id_valid                  ID holds a real instruction
//   id_Rn, id_Rm, id_Rd       source/destination register numbers (5 bits)
//   id_RegData1, id_RegData2  register-file read data for Rn / Rm (64 bits)
//   id_Imm                    sign-extended immediate (64 bits)
//   id_ctrl                   {RegWrite, MemRead, MemWrite, MemToReg,
//                              ALUSrc, ALUOp[2:0]}
//   flush                     squash the ID instruction (taken branch)
//   mem_RegWrite/Rd/Result    EX/MEM writer (forwarding source, youngest)
//   wb_RegWrite/Rd/Data       MEM/WB writer (same write as the reg file)
//   stall                     load-use hazard; PC and IF/ID hold
//   ex_valid, ex_A, ex_B, ex_Imm, ex_Rd, ex_ctrl
//                             registered EX-stage operands and control
// ---------------------------------------------------------------------------
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_Rn,
  input  logic [4:0]  id_Rm,
  input  logic [4:0]  id_Rd,
  input  logic [63:0] id_RegData1,
  input  logic [63:0] id_RegData2,
  input  logic [63:0] id_Imm,
  input  logic [7:0]  id_ctrl,
  input  logic        flush,
  input  logic        mem_RegWrite,
  input  logic [4:0]  mem_Rd,
  input  logic [63:0] mem_Result,
  input  logic        wb_RegWrite,
  input  logic [4:0]  wb_Rd,
  input  logic [63:0] wb_Data,
  output logic        stall,
  output logic        ex_valid,
  output logic [63:0] ex_A,
  output logic [63:0] ex_B,
  output logic [63:0] ex_Imm,
  output logic [4:0]  ex_Rd,
  output logic [7:0]  ex_ctrl
);

  localparam logic [4:0] XZR         = 5'd31;
  localparam int         CTRL_MEMRD  = 6;

  logic        ex_valid_q, ex_valid_d;
  logic [63:0] ex_a_q,     ex_a_d;
  logic [63:0] ex_b_q,     ex_b_d;
  logic [63:0] ex_imm_q,   ex_imm_d;
  logic [4:0]  ex_rd_q,    ex_rd_d;
  logic [7:0]  ex_ctrl_q,  ex_ctrl_d;

  logic        bubble;
  logic [63:0] op_a;
  logic [63:0] op_b;

  // Operand select. X31 always reads zero, so checking the source register
  // first also guarantees that a writer targeting X31 is never forwarded.
  // MEM is checked before WB so the younger result wins.
  function automatic logic [63:0] select_operand(
    input logic [4:0]  src,
    input logic [63:0] rf_data,
    input logic        mem_we,
    input logic [4:0]  mem_rd,
    input logic [63:0] mem_val,
    input logic        wb_we,
    input logic [4:0]  wb_rd,
    input logic [63:0] wb_val
  );
    logic [63:0] result;
    if (src == XZR) begin
      result = 64'd0;
    end else if (mem_we && (mem_rd == src)) begin
      result = mem_val;
    end else if (wb_we && (wb_rd == src)) begin
      result = wb_val;
    end else begin
      result = rf_data;
    end
    return result;
  endfunction

  // Load-use hazard: the EX instruction is a load whose (non-X31) target is
  // a source of the ID instruction. Because the bubble clears ex_valid, this
  // can only hold for one cycle per load.
  always_comb begin
    stall = id_valid && ex_valid_q && ex_ctrl_q[CTRL_MEMRD] &&
            (ex_rd_q != XZR) &&
            ((ex_rd_q == id_Rn) || (ex_rd_q == id_Rm));
  end

  always_comb begin
    op_a = select_operand(id_Rn, id_RegData1, mem_RegWrite, mem_Rd, mem_Result,
                          wb_RegWrite, wb_Rd, wb_Data);
    op_b = select_operand(id_Rm, id_RegData2, mem_RegWrite, mem_Rd, mem_Result,
                          wb_RegWrite, wb_Rd, wb_Data);
  end

  // A bubble only kills valid and control; the datapath fields keep their
  // old values so nothing toggles needlessly in EX.
  always_comb begin
    bubble     = stall || flush || !id_valid;
    ex_valid_d = 1'b0;
    ex_ctrl_d  = 8'd0;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_imm_d   = ex_imm_q;
    ex_rd_d    = ex_rd_q;
    if (!bubble) begin
      ex_valid_d = 1'b1;
      ex_ctrl_d  = id_ctrl;
      ex_a_d     = op_a;
      ex_b_d     = op_b;
      ex_imm_d   = id_Imm;
      ex_rd_d    = id_Rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q <= 1'b0;
      ex_a_q     <= 64'd0;
      ex_b_q     <= 64'd0;
      ex_imm_q   <= 64'd0;
      ex_rd_q    <= 5'd0;
      ex_ctrl_q  <= 8'd0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_imm_q   <= ex_imm_d;
      ex_rd_q    <= ex_rd_d;
      ex_ctrl_q  <= ex_ctrl_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_A     = ex_a_q;
  assign ex_B     = ex_b_q;
  assign ex_Imm   = ex_imm_q;
  assign ex_Rd    = ex_rd_q;
  assign ex_ctrl  = ex_ctrl_q;

endmodule
